lives_controller: RTL and testbench
===================================

// Module: lives_controller
// PURPOSE
//  Parametrised Pac-Man life/death sequencer in the game_control layer. It owns
//  the lives count, death/respawn sequencing and post-respawn invulnerability.
//  It awards bonus lives at a configurable binary-score schedule, with a max-lives cap.
//  It feeds the HUD (lives), the ghost/PM reset logic (respawn_req) and the game-over screen.
// PARAMETERS
//  LIFE_W        3     width of lives/init count
//  MAX_LIVES     5     saturation cap for lives (must be < 2**LIFE_W)
//  SCORE_W       16    width of binary score input
//  FIRST_BONUS   500   score at which the first bonus life is awarded
//  BONUS_STEP    1000  score increment between subsequent bonus thresholds (>0)
//  DEATH_FRAMES  90    frames held in DYING (death animation), >=1
//  INVULN_FRAMES 120   frames of collision immunity after respawn, >=1
// PORTS
//  clk                  in  1        system clock
//  resetN               in  1        synchronous active-low reset
//  game_started         in  1        level; low forces IDLE and reloads lives
//  start_of_frame       in  1        1-cycle pulse per video frame
//  collision_with_ghost in  1        level, PM overlaps a ghost
//  is_frightened        in  1        ghosts frightened: collisions not lethal
//  init_live_count      in  LIFE_W   lives at game start
//  score                in  SCORE_W  current binary score, monotonic in a game
//  lives                out LIFE_W   current lives
//  lost_life            out 1        1-cycle pulse on lethal hit
//  extra_life           out 1        1-cycle pulse when a bonus life is added
//  respawn_req          out 1        1-cycle pulse: reposition PM and ghosts
//  invulnerable         out 1        state==INVULN
//  is_pm_alive          out 1        state is PLAYING or INVULN
//  game_over            out 1        state==GAME_OVER
// BEHAVIOUR
//  - Reset, and any cycle with game_started=0:
//    - state=IDLE; lives=min(init_live_count,MAX_LIVES).
//    - next_bonus=FIRST_BONUS; frame counter=0; all pulses 0.
//    - Reset mid-sequence aborts it cleanly.
//  - States: IDLE, PLAYING, DYING, INVULN, GAME_OVER. All outputs registered.
//  - IDLE -> PLAYING the cycle after game_started=1.
//  - Lethal hit: PLAYING & collision_with_ghost & ~is_frightened. Next cycle:
//    - lives-=1; lost_life=1; state=DYING; cnt=DEATH_FRAMES.
//  - DYING: cnt decrements on each start_of_frame. Acting on the pulse that
//    takes cnt to 0:
//    - lives==0: -> GAME_OVER.
//    - else: -> INVULN, respawn_req=1 that cycle, cnt=INVULN_FRAMES.
//  - INVULN: collisions ignored; cnt decrements per start_of_frame.
//    The pulse that takes cnt to 0 moves the state to PLAYING.
//  - GAME_OVER: sticky until game_started=0 or reset; no lives change.
//  - Bonus: next_bonus is SCORE_W+1 bits, so it cannot wrap. Eligible in
//    PLAYING/DYING/INVULN when score>=next_bonus. Then:
//    - next_bonus+=BONUS_STEP.
//    - If lives<MAX_LIVES: lives+=1 and extra_life=1; at cap only the threshold advances.
//    - At most one award per cycle: a score jump over k thresholds yields k
//      awards on k consecutive cycles.
//    - Once next_bonus exceeds 2**SCORE_W-1 no further awards occur.
//  - Lethal hit and bonus in the same cycle: the hit wins. next_bonus is not
//    advanced, so the bonus is taken on a later cycle (lives net unchanged).
//  - A bonus during DYING with lives==0 rescues the PM: cnt expiry goes to
//    INVULN, not GAME_OVER.
//  - A collision held across the hit cycle cannot cause a second decrement:
//    the state has already left PLAYING.
// TESTING
//  - init=3, hit with is_frightened=0 -> lives 2, lost_life 1 cycle, DYING;
//    90 frames later respawn_req pulse, INVULN.
//  - In INVULN, hold collision 120 frames -> lives stays 2; then PLAYING;
//    next hit -> lives 1.
//  - lives=1, hit -> lives 0; after DEATH_FRAMES -> game_over=1, is_pm_alive=0;
//    game_started=0 -> IDLE, lives=init.
//  - score 0->2600 in one step, lives=1 -> extra_life on 3 consecutive cycles
//    (500,1500,2500), lives=4, next_bonus=3500.
//  - lives=MAX_LIVES, score crosses 500 -> no extra_life, lives unchanged,
//    next_bonus=1500.
//  - Hit and score crossing 500 same cycle, lives=2 -> lives 1 then 2 next
//    cycle; lost_life then extra_life.

Source files
------------

// File: rtl/lives_controller.sv
// Pac-Man life/death sequencer: lives count, death and respawn timing,
// post-respawn invulnerability and score-driven bonus lives with a cap.
module lives_controller #(
   parameter int LIFE_W        = 3,
   parameter int MAX_LIVES     = 5,
   parameter int SCORE_W       = 16,
   parameter int FIRST_BONUS   = 500,
   parameter int BONUS_STEP    = 1000,
   parameter int DEATH_FRAMES  = 90,
   parameter int INVULN_FRAMES = 120
) (
   input  logic              clk,
   input  logic              resetN,
   input  logic              game_started,
   input  logic              start_of_frame,
   input  logic              collision_with_ghost,
   input  logic              is_frightened,
   input  logic [LIFE_W-1:0] init_live_count,
   input  logic [SCORE_W-1:0] score,
   output logic [LIFE_W-1:0] lives,
   output logic              lost_life,
   output logic              extra_life,
   output logic              respawn_req,
   output logic              invulnerable,
   output logic              is_pm_alive,
   output logic              game_over
);

   localparam int CNT_MAX = (DEATH_FRAMES > INVULN_FRAMES) ? DEATH_FRAMES : INVULN_FRAMES;
   localparam int CNT_W   = $clog2(CNT_MAX + 1);

   localparam logic [LIFE_W-1:0]  MAX_L     = LIFE_W'(MAX_LIVES);
   localparam logic [LIFE_W-1:0]  ONE_L     = LIFE_W'(1);
   localparam logic [SCORE_W:0]   FIRST_B   = (SCORE_W+1)'(FIRST_BONUS);
   localparam logic [SCORE_W:0]   STEP_B    = (SCORE_W+1)'(BONUS_STEP);
   localparam logic [CNT_W-1:0]   DEATH_C   = CNT_W'(DEATH_FRAMES);
   localparam logic [CNT_W-1:0]   INVULN_C  = CNT_W'(INVULN_FRAMES);
   localparam logic [CNT_W-1:0]   ONE_C     = CNT_W'(1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_PLAYING,
      S_DYING,
      S_INVULN,
      S_GAME_OVER
   } state_t;

   state_t            state;
   logic [SCORE_W:0]  next_bonus;
   logic [CNT_W-1:0]  cnt;

   logic [LIFE_W-1:0] init_clamped;
   logic              lethal;
   logic              bonus_due;
   logic              award;
   logic              lives_up;
   logic              cnt_expire;

   // The extra threshold bit keeps next_bonus from wrapping past the score range.
   assign init_clamped = (init_live_count > MAX_L) ? MAX_L : init_live_count;
   assign lethal       = collision_with_ghost & ~is_frightened;
   assign bonus_due    = ({1'b0, score} >= next_bonus);
   assign lives_up     = lives < MAX_L;
   assign cnt_expire   = start_of_frame && (cnt == ONE_C);

   // A lethal hit in PLAYING takes priority; the threshold is left for a later cycle.
   assign award = bonus_due &&
                  (((state == S_PLAYING) && !lethal) ||
                   (state == S_DYING) || (state == S_INVULN));

   // NOTE: all state here uses non-blocking assignments so every register
   // samples pre-edge values, regardless of statement order in the block.
   always_ff @(posedge clk) begin
      lost_life   <= 1'b0;
      extra_life  <= 1'b0;
      respawn_req <= 1'b0;

      if (!resetN || !game_started) begin
         state        <= S_IDLE;
         lives        <= init_clamped;
         next_bonus   <= FIRST_B;
         cnt          <= '0;
         invulnerable <= 1'b0;
         is_pm_alive  <= 1'b0;
         game_over    <= 1'b0;
      end else begin
         case (state)
            S_IDLE: begin
               state       <= S_PLAYING;
               is_pm_alive <= 1'b1;
            end

            S_PLAYING: begin
               if (lethal) begin
                  state       <= S_DYING;
                  lives       <= (lives == '0) ? '0 : lives - ONE_L;
                  lost_life   <= 1'b1;
                  cnt         <= DEATH_C;
                  is_pm_alive <= 1'b0;
               end
            end

            S_DYING: begin
               if (start_of_frame) begin
                  cnt <= cnt - ONE_C;
                  if (cnt_expire) begin
                     // A bonus landing on the expiry cycle still rescues the last life.
                     if ((lives == '0) && !(award && lives_up)) begin
                        state     <= S_GAME_OVER;
                        game_over <= 1'b1;
                     end else begin
                        state        <= S_INVULN;
                        respawn_req  <= 1'b1;
                        cnt          <= INVULN_C;
                        invulnerable <= 1'b1;
                        is_pm_alive  <= 1'b1;
                     end
                  end
               end
            end

            S_INVULN: begin
               if (start_of_frame) begin
                  cnt <= cnt - ONE_C;
                  if (cnt_expire) begin
                     state        <= S_PLAYING;
                     invulnerable <= 1'b0;
                  end
               end
            end

            S_GAME_OVER: begin
               state <= S_GAME_OVER;
            end

            default: begin
               state        <= S_IDLE;
               invulnerable <= 1'b0;
               is_pm_alive  <= 1'b0;
               game_over    <= 1'b0;
            end
         endcase

         if (award) begin
            next_bonus <= next_bonus + STEP_B;
            if (lives_up) begin
               lives      <= lives + ONE_L;
               extra_life <= 1'b1;
            end
         end
      end
   end

endmodule

// File: tb/tb_lives_controller.sv
// Scoreboard bench for lives_controller: the driver queues expected output
// snapshots, a negedge monitor pops and compares them.
module tb_lives_controller;

   logic        clk = 1'b0;
   logic        resetN;
   logic        game_started;
   logic        start_of_frame;
   logic        collision_with_ghost;
   logic        is_frightened;
   logic [2:0]  init_live_count;
   logic [15:0] score;
   logic [2:0]  lives;
   logic        lost_life;
   logic        extra_life;
   logic        respawn_req;
   logic        invulnerable;
   logic        is_pm_alive;
   logic        game_over;

   typedef struct {
      string      name;
      logic [8:0] snap;   // {lost, extra, respawn, lives[2:0], inv, alive, game_over}
   } exp_t;

   exp_t exp_q[$];
   logic probe = 1'b0;
   int   n_checks = 0;
   int   n_fail = 0;

   always #5 clk = ~clk;

   lives_controller dut (
      .clk                  (clk),
      .resetN               (resetN),
      .game_started         (game_started),
      .start_of_frame       (start_of_frame),
      .collision_with_ghost (collision_with_ghost),
      .is_frightened        (is_frightened),
      .init_live_count      (init_live_count),
      .score                (score),
      .lives                (lives),
      .lost_life            (lost_life),
      .extra_life           (extra_life),
      .respawn_req          (respawn_req),
      .invulnerable         (invulnerable),
      .is_pm_alive          (is_pm_alive),
      .game_over            (game_over)
   );

   // Monitor: compares on probed cycles, flags any pulse nobody expected.
   always @(negedge clk) begin
      logic [8:0] got;
      exp_t       e;
      got = {lost_life, extra_life, respawn_req, lives, invulnerable, is_pm_alive, game_over};
      if (probe) begin
         n_checks++;
         if (exp_q.size() == 0) begin
            n_fail++;
            $display("FAIL probe_without_expectation: got %b", got);
         end else begin
            e = exp_q.pop_front();
            if (got !== e.snap) begin
               n_fail++;
               $display("FAIL %s: got %b expected %b (lost,extra,resp,lives,inv,alive,go)",
                        e.name, got, e.snap);
            end
         end
      end else if (lost_life || extra_life || respawn_req) begin
         n_checks++;
         n_fail++;
         $display("FAIL unexpected_pulse at %0t: got lost=%b extra=%b resp=%b expected none",
                  $time, lost_life, extra_life, respawn_req);
      end
   end

   task automatic tick();
      @(posedge clk);
      #1;
      probe = 1'b0;
   endtask

   task automatic expect_out(input string name, input logic [2:0] lv, input logic lost,
                             input logic extra, input logic resp, input logic inv,
                             input logic alive, input logic go);
      exp_t e;
      e.name = name;
      e.snap = {lost, extra, resp, lv, inv, alive, go};
      exp_q.push_back(e);
      probe = 1'b1;
   endtask

   task automatic frames(input int n);
      for (int i = 0; i < n; i++) begin
         start_of_frame = 1'b1;
         tick();
         start_of_frame = 1'b0;
         tick();
      end
   endtask

   task automatic last_frame();
      start_of_frame = 1'b1;
      tick();
      start_of_frame = 1'b0;
   endtask

   initial begin
      #2_000_000;
      n_fail++;
      $display("FAIL watchdog: got timeout expected end of stimulus");
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

   initial begin
      resetN = 1'b0; game_started = 1'b0; start_of_frame = 1'b0;
      collision_with_ghost = 1'b0; is_frightened = 1'b0;
      init_live_count = 3'd3; score = 16'd0;

      // Reset and first game: init=3
      tick(); tick();
      expect_out("reset", 3'd3, 0, 0, 0, 0, 0, 0);
      tick();
      resetN = 1'b1; game_started = 1'b1;
      tick(); expect_out("idle_to_play", 3'd3, 0, 0, 0, 0, 1, 0);
      collision_with_ghost = 1'b1;
      tick(); expect_out("hit1", 3'd2, 1, 0, 0, 0, 0, 0);
      tick(); expect_out("held_collision", 3'd2, 0, 0, 0, 0, 0, 0);
      collision_with_ghost = 1'b0;
      frames(89);
      expect_out("dying_89_frames", 3'd2, 0, 0, 0, 0, 0, 0);
      last_frame(); expect_out("respawn1", 3'd2, 0, 0, 1, 1, 1, 0);

      // Collision held through all of INVULN, then a real hit
      collision_with_ghost = 1'b1;
      frames(119);
      expect_out("invuln_119_frames", 3'd2, 0, 0, 0, 1, 1, 0);
      last_frame(); expect_out("invuln_end", 3'd2, 0, 0, 0, 0, 1, 0);
      tick(); expect_out("hit2", 3'd1, 1, 0, 0, 0, 0, 0);
      collision_with_ghost = 1'b0;
      frames(89);
      last_frame(); expect_out("respawn2", 3'd1, 0, 0, 1, 1, 1, 0);
      frames(119);
      last_frame(); expect_out("play_again", 3'd1, 0, 0, 0, 0, 1, 0);

      // Last life lost -> GAME_OVER, sticky, released by game_started=0
      collision_with_ghost = 1'b1;
      tick(); expect_out("hit_last", 3'd0, 1, 0, 0, 0, 0, 0);
      collision_with_ghost = 1'b0;
      frames(89);
      last_frame(); expect_out("game_over", 3'd0, 0, 0, 0, 0, 0, 1);
      collision_with_ghost = 1'b1; score = 16'd600;
      tick(); tick(); expect_out("game_over_sticky", 3'd0, 0, 0, 0, 0, 0, 1);
      collision_with_ghost = 1'b0;
      game_started = 1'b0; score = 16'd0;
      tick(); expect_out("go_to_idle", 3'd3, 0, 0, 0, 0, 0, 0);

      // Score jump over three thresholds, then cap behaviour
      init_live_count = 3'd1;
      tick(); expect_out("idle_init1", 3'd1, 0, 0, 0, 0, 0, 0);
      game_started = 1'b1;
      tick(); expect_out("play_init1", 3'd1, 0, 0, 0, 0, 1, 0);
      score = 16'd2600;
      tick(); expect_out("bonus_500", 3'd2, 0, 1, 0, 0, 1, 0);
      tick(); expect_out("bonus_1500", 3'd3, 0, 1, 0, 0, 1, 0);
      tick(); expect_out("bonus_2500", 3'd4, 0, 1, 0, 0, 1, 0);
      tick(); expect_out("no_bonus_2600", 3'd4, 0, 0, 0, 0, 1, 0);
      score = 16'd3499;
      tick(); expect_out("no_bonus_3499", 3'd4, 0, 0, 0, 0, 1, 0);
      score = 16'd3500;
      tick(); expect_out("bonus_3500", 3'd5, 0, 1, 0, 0, 1, 0);
      score = 16'd4500;
      tick(); expect_out("cap_4500", 3'd5, 0, 0, 0, 0, 1, 0);
      score = 16'd5499;
      tick(); expect_out("cap_5499", 3'd5, 0, 0, 0, 0, 1, 0);
      collision_with_ghost = 1'b1;
      tick(); expect_out("hit_at_cap", 3'd4, 1, 0, 0, 0, 0, 0);
      collision_with_ghost = 1'b0;
      tick(); expect_out("dying_5499", 3'd4, 0, 0, 0, 0, 0, 0);
      score = 16'd5500;
      tick(); expect_out("bonus_5500_dying", 3'd5, 0, 1, 0, 0, 0, 0);

      // Init above cap clamps to MAX_LIVES; crossing 500 at cap only advances threshold
      game_started = 1'b0; score = 16'd0; init_live_count = 3'd7;
      tick(); expect_out("init_clamp", 3'd5, 0, 0, 0, 0, 0, 0);
      game_started = 1'b1;
      tick(); expect_out("play_clamp", 3'd5, 0, 0, 0, 0, 1, 0);
      score = 16'd500;
      tick(); expect_out("cap_500", 3'd5, 0, 0, 0, 0, 1, 0);
      collision_with_ghost = 1'b1;
      tick(); expect_out("hit_after_cap", 3'd4, 1, 0, 0, 0, 0, 0);
      collision_with_ghost = 1'b0;
      tick(); expect_out("threshold_1500", 3'd4, 0, 0, 0, 0, 0, 0);
      score = 16'd1500;
      tick(); expect_out("bonus_1500_dying", 3'd5, 0, 1, 0, 0, 0, 0);

      // Hit and threshold crossing on the same cycle
      game_started = 1'b0; score = 16'd0; init_live_count = 3'd2;
      tick(); expect_out("idle_init2", 3'd2, 0, 0, 0, 0, 0, 0);
      game_started = 1'b1;
      tick(); expect_out("play_init2", 3'd2, 0, 0, 0, 0, 1, 0);
      collision_with_ghost = 1'b1; score = 16'd500;
      tick(); expect_out("hit_wins", 3'd1, 1, 0, 0, 0, 0, 0);
      collision_with_ghost = 1'b0;
      tick(); expect_out("bonus_after_hit", 3'd2, 0, 1, 0, 0, 0, 0);

      // Bonus while dying with zero lives rescues the PM
      game_started = 1'b0; score = 16'd0; init_live_count = 3'd1;
      tick(); expect_out("idle_rescue", 3'd1, 0, 0, 0, 0, 0, 0);
      game_started = 1'b1;
      tick(); expect_out("play_rescue", 3'd1, 0, 0, 0, 0, 1, 0);
      collision_with_ghost = 1'b1;
      tick(); expect_out("hit_to_zero", 3'd0, 1, 0, 0, 0, 0, 0);
      collision_with_ghost = 1'b0; score = 16'd500;
      tick(); expect_out("rescue_bonus", 3'd1, 0, 1, 0, 0, 0, 0);
      frames(89);
      last_frame(); expect_out("rescue_respawn", 3'd1, 0, 0, 1, 1, 1, 0);

      // Reset in the middle of INVULN, then frightened collisions are harmless
      init_live_count = 3'd4; resetN = 1'b0;
      tick(); expect_out("reset_mid", 3'd4, 0, 0, 0, 0, 0, 0);
      resetN = 1'b1; score = 16'd0;
      tick(); expect_out("after_reset", 3'd4, 0, 0, 0, 0, 1, 0);
      is_frightened = 1'b1; collision_with_ghost = 1'b1;
      tick(); tick(); expect_out("frightened", 3'd4, 0, 0, 0, 0, 1, 0);
      collision_with_ghost = 1'b0; is_frightened = 1'b0;
      tick(); tick();

      n_checks++;
      if (exp_q.size() != 0) begin
         n_fail++;
         $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
      end
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
